// File: rtl/iob_axi_pkg.sv
// Shared AXI4 constants and bridge FSM encoding for the native-to-AXI bridge.
package iob_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } bridge_state_t;

endpackage

// File: rtl/iob_native2axi_bridge.sv
// Turns single-word native memory requests into single-beat AXI4 transactions,
// one outstanding at a time, completing each with a one-cycle mem_ready pulse.
module iob_native2axi_bridge
    import iob_axi_pkg::*;
#(
    parameter int MEM_ADDR_W = 32,
    parameter int MEM_DATA_W = 32,
    parameter int AXI_ID_W   = 1,
    localparam int MEM_N_BYTES = MEM_DATA_W / 8,
    localparam int BYTE_OFF_W  = $clog2(MEM_N_BYTES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_valid,
    input  logic [MEM_ADDR_W-BYTE_OFF_W-1:0] mem_addr,
    input  logic [MEM_DATA_W-1:0]        mem_wdata,
    input  logic [MEM_N_BYTES-1:0]       mem_wstrb,
    output logic [MEM_DATA_W-1:0]        mem_rdata,
    output logic                         mem_ready,
    output logic                         mem_err,
    output logic [AXI_ID_W-1:0]          axi_awid,
    output logic [MEM_ADDR_W-1:0]        axi_awaddr,
    output logic [7:0]                   axi_awlen,
    output logic [2:0]                   axi_awsize,
    output logic [1:0]                   axi_awburst,
    output logic                         axi_awlock,
    output logic [3:0]                   axi_awcache,
    output logic [2:0]                   axi_awprot,
    output logic [3:0]                   axi_awqos,
    output logic                         axi_awvalid,
    input  logic                         axi_awready,
    output logic [MEM_DATA_W-1:0]        axi_wdata,
    output logic [MEM_N_BYTES-1:0]       axi_wstrb,
    output logic                         axi_wlast,
    output logic                         axi_wvalid,
    input  logic                         axi_wready,
    input  logic [AXI_ID_W-1:0]          axi_bid,
    input  logic [1:0]                   axi_bresp,
    input  logic                         axi_bvalid,
    output logic                         axi_bready,
    output logic [AXI_ID_W-1:0]          axi_arid,
    output logic [MEM_ADDR_W-1:0]        axi_araddr,
    output logic [7:0]                   axi_arlen,
    output logic [2:0]                   axi_arsize,
    output logic [1:0]                   axi_arburst,
    output logic                         axi_arlock,
    output logic [3:0]                   axi_arcache,
    output logic [2:0]                   axi_arprot,
    output logic [3:0]                   axi_arqos,
    output logic                         axi_arvalid,
    input  logic                         axi_arready,
    input  logic [AXI_ID_W-1:0]          axi_rid,
    input  logic [MEM_DATA_W-1:0]        axi_rdata,
    input  logic [1:0]                   axi_rresp,
    input  logic                         axi_rlast,
    input  logic                         axi_rvalid,
    output logic                         axi_rready
);

    bridge_state_t                    state_q, state_d;
    logic [MEM_ADDR_W-BYTE_OFF_W-1:0] addr_q, addr_d;
    logic [MEM_DATA_W-1:0]            wdata_q, wdata_d;
    logic [MEM_N_BYTES-1:0]           wstrb_q, wstrb_d;
    logic [MEM_DATA_W-1:0]            rdata_q, rdata_d;
    logic arvalid_q, arvalid_d;
    logic awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d;
    logic rready_q, rready_d;
    logic bready_q, bready_d;
    logic mem_ready_q, mem_ready_d;
    logic mem_err_q, mem_err_d;
    logic unused_ids;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        arvalid_d   = arvalid_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        rready_d    = rready_q;
        bready_d    = bready_q;
        mem_ready_d = 1'b0;
        mem_err_d   = mem_err_q;
        unique case (state_q)
            IDLE: begin
                // The requester still holds mem_valid during the mem_ready cycle.
                if (mem_valid && !mem_ready_q) begin
                    addr_d    = mem_addr;
                    wdata_d   = mem_wdata;
                    wstrb_d   = mem_wstrb;
                    mem_err_d = 1'b0;
                    if (mem_wstrb == '0) begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end else begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end
                end
            end
            RD_ADDR: begin
                if (arvalid_q && axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                // Non-last beats are consumed but only the last one is returned.
                if (rready_q && axi_rvalid && axi_rlast) begin
                    rdata_d     = axi_rdata;
                    mem_err_d   = (axi_rresp != AXI_RESP_OKAY);
                    mem_ready_d = 1'b1;
                    rready_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            WR_REQ: begin
                // Each pending valid doubles as the not-yet-done flag of its channel.
                if (awvalid_q && axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready_q && axi_bvalid) begin
                    mem_err_d   = (axi_bresp != AXI_RESP_OKAY);
                    mem_ready_d = 1'b1;
                    bready_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            arvalid_q   <= arvalid_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            rready_q    <= rready_d;
            bready_q    <= bready_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;

    assign axi_awid    = '0;
    assign axi_awaddr  = MEM_ADDR_W'(addr_q) << BYTE_OFF_W;
    assign axi_awlen   = 8'd0;
    assign axi_awsize  = 3'(BYTE_OFF_W);
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_awlock  = 1'b0;
    assign axi_awcache = AXI_CACHE_DEFAULT;
    assign axi_awprot  = AXI_PROT_DEFAULT;
    assign axi_awqos   = 4'd0;
    assign axi_awvalid = awvalid_q;

    assign axi_wdata  = wdata_q;
    assign axi_wstrb  = wstrb_q;
    assign axi_wlast  = 1'b1;
    assign axi_wvalid = wvalid_q;
    assign axi_bready = bready_q;

    assign axi_arid    = '0;
    assign axi_araddr  = MEM_ADDR_W'(addr_q) << BYTE_OFF_W;
    assign axi_arlen   = 8'd0;
    assign axi_arsize  = 3'(BYTE_OFF_W);
    assign axi_arburst = AXI_BURST_INCR;
    assign axi_arlock  = 1'b0;
    assign axi_arcache = AXI_CACHE_DEFAULT;
    assign axi_arprot  = AXI_PROT_DEFAULT;
    assign axi_arqos   = 4'd0;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;

    // Only one transaction is ever in flight, so response IDs carry no information.
    assign unused_ids = ^{axi_bid, axi_rid};

endmodule

// File: tb/tb_iob_native2axi_bridge.sv
// Directed bench for iob_native2axi_bridge: table of native accesses against an
// in-bench AXI slave with per-vector handshake delays and response codes.
module tb_iob_native2axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready, mem_err;
    logic [0:0]  axi_awid, axi_arid, axi_bid, axi_rid;
    logic [31:0] axi_awaddr, axi_araddr;
    logic [7:0]  axi_awlen, axi_arlen;
    logic [2:0]  axi_awsize, axi_arsize, axi_awprot, axi_arprot;
    logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
    logic        axi_awlock, axi_arlock;
    logic [3:0]  axi_awcache, axi_arcache, axi_awqos, axi_arqos;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
    logic [31:0] axi_wdata, axi_rdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic        axi_rlast, axi_rvalid, axi_rready;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [0:15];

    typedef struct {
        bit          wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          dly_a;   // AW (or AR) ready delay in cycles
        int          dly_w;   // W ready delay in cycles
        logic [1:0]  resp;
        int          beats;   // R beats returned, last one carries the data
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    iob_native2axi_bridge dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_err(mem_err),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arqos(axi_arqos),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [29:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int dly_a, input int dly_w,
                                input logic [1:0] resp, input int beats,
                                input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.dly_a = dly_a; v.dly_w = dly_w; v.resp = resp; v.beats = beats;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic idle_slave();
        axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
        axi_bvalid = 1'b0; axi_bresp = 2'b00; axi_bid = 1'b0;
        axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
        axi_rdata = 32'h0; axi_rid = 1'b0;
    endtask

    // Issues one native access (must be called just after a falling edge) and
    // plays the AXI slave; the requester drops mem_valid one cycle after mem_ready.
    task automatic do_access(input vec_t v, input string tag);
        int pulses = 0, lat = -1, drop_at = -1;
        int aw_hs = 0, w_hs = 0, ar_hs = 0, r_left = 0;
        bit b_pend = 0, b_seen = 0;
        logic [31:0] c_awaddr = '0, c_araddr = '0, c_wdata = '0, c_rdata = '0;
        logic [3:0]  c_wstrb = '0;
        logic [7:0]  c_len = '0;
        logic [2:0]  c_size = '0;
        logic [1:0]  c_burst = '0;
        logic        c_wlast = 1'b0, c_err = 1'b0;
        logic [31:0] rd_addr;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wr ? v.wstrb : 4'h0;
        mem_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (mem_ready) begin
                pulses++;
                if (lat < 0) begin
                    lat = cyc; c_rdata = mem_rdata; c_err = mem_err; drop_at = cyc + 1;
                end
            end
            if (cyc == drop_at) mem_valid = 1'b0;
            if (drop_at >= 0 && cyc == drop_at + 3) break;
            axi_awready = (cyc >= v.dly_a);
            axi_wready  = (cyc >= v.dly_w);
            axi_arready = (cyc >= v.dly_a);
            axi_bvalid  = b_pend;
            axi_bresp   = v.resp;
            rd_addr     = c_araddr >> 2;
            axi_rvalid  = (r_left > 0);
            axi_rlast   = (r_left == 1);
            axi_rresp   = v.resp;
            axi_rdata   = (r_left == 1) ? mem[rd_addr[3:0]] : 32'hBAD0_BAD0;
            if (axi_awvalid && axi_awready) begin
                aw_hs++; c_awaddr = axi_awaddr; c_len = axi_awlen;
                c_size = axi_awsize; c_burst = axi_awburst;
            end
            if (axi_wvalid && axi_wready) begin
                w_hs++; c_wdata = axi_wdata; c_wstrb = axi_wstrb; c_wlast = axi_wlast;
            end
            if (axi_bvalid && axi_bready) b_pend = 0;
            if (axi_arvalid && axi_arready) begin
                ar_hs++; c_araddr = axi_araddr; r_left = v.beats; c_len = axi_arlen;
                c_size = axi_arsize; c_burst = axi_arburst;
            end
            if (axi_rvalid && axi_rready) r_left--;
            if (aw_hs > 0 && w_hs > 0 && !b_seen) begin
                b_seen = 1; b_pend = 1;
                for (int b = 0; b < 4; b++)
                    if (c_wstrb[b]) mem[c_awaddr[5:2]][8*b +: 8] = c_wdata[8*b +: 8];
            end
        end
        mem_valid = 1'b0;
        idle_slave();
        chk({tag, " pulses"}, pulses, 1);
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " rdata"}, c_rdata, v.exp_rdata);
        chk({tag, " err"}, c_err, v.exp_err);
        chk({tag, " len/size/burst"}, {c_len, c_size, c_burst}, {8'd0, 3'd2, 2'b01});
        if (v.wr) begin
            chk({tag, " aw/w/ar count"}, {aw_hs[7:0], w_hs[7:0], ar_hs[7:0]}, {8'd1, 8'd1, 8'd0});
            chk({tag, " awaddr"}, c_awaddr, {v.addr, 2'b00});
            chk({tag, " wdata"}, c_wdata, v.wdata);
            chk({tag, " wstrb/wlast"}, {c_wstrb, c_wlast}, {v.wstrb, 1'b1});
        end else begin
            chk({tag, " aw/w/ar count"}, {aw_hs[7:0], w_hs[7:0], ar_hs[7:0]}, {8'd0, 8'd0, 8'd1});
            chk({tag, " araddr"}, c_araddr, {v.addr, 2'b00});
        end
    endtask

    initial begin
        logic any_out;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[8] = 32'h8888_0008;

        // wr addr wdata wstrb dly_a dly_w resp beats exp_rdata exp_err exp_lat
        vecs[0]  = mk(1, 30'd4, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 1, 32'h0,        0, 2);
        vecs[1]  = mk(0, 30'd4, 32'h0,        4'h0, 0, 0, 2'b00, 1, 32'hDEADBEEF, 0, 2);
        vecs[2]  = mk(1, 30'd1, 32'h1,        4'hF, 3, 0, 2'b00, 1, 32'hDEADBEEF, 0, 5);
        vecs[3]  = mk(1, 30'd2, 32'h2,        4'hF, 0, 3, 2'b00, 1, 32'hDEADBEEF, 0, 5);
        vecs[4]  = mk(1, 30'd3, 32'h3,        4'hF, 2, 2, 2'b00, 1, 32'hDEADBEEF, 0, 4);
        vecs[5]  = mk(0, 30'd1, 32'h0,        4'h0, 0, 0, 2'b00, 1, 32'h1,        0, 2);
        vecs[6]  = mk(0, 30'd2, 32'h0,        4'h0, 0, 0, 2'b00, 1, 32'h2,        0, 2);
        vecs[7]  = mk(0, 30'd3, 32'h0,        4'h0, 1, 0, 2'b00, 1, 32'h3,        0, 3);
        vecs[8]  = mk(1, 30'd5, 32'hCAFEF00D, 4'hF, 0, 0, 2'b10, 1, 32'h3,        1, 2);
        vecs[9]  = mk(0, 30'd5, 32'h0,        4'h0, 0, 0, 2'b11, 1, 32'hCAFEF00D, 1, 2);
        vecs[10] = mk(0, 30'd4, 32'h0,        4'h0, 0, 0, 2'b00, 1, 32'hDEADBEEF, 0, 2);
        vecs[11] = mk(1, 30'd4, 32'h11223344, 4'h5, 1, 0, 2'b00, 1, 32'hDEADBEEF, 0, 3);
        vecs[12] = mk(0, 30'd4, 32'h0,        4'h0, 0, 0, 2'b00, 2, 32'hDE22BE44, 0, 3);

        reset = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        idle_slave();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle outputs c%0d", i),
                {axi_awvalid, axi_wvalid, axi_arvalid, axi_rready, axi_bready, mem_ready, mem_err},
                7'b0);
            chk($sformatf("idle rdata c%0d", i), mem_rdata, 32'h0);
        end
        chk("const aw fields", {axi_awid, axi_awlock, axi_awcache, axi_awprot, axi_awqos},
            {1'b0, 1'b0, 4'b0011, 3'b010, 4'b0000});
        chk("const ar fields", {axi_arid, axi_arlock, axi_arcache, axi_arprot, axi_arqos},
            {1'b0, 1'b0, 4'b0011, 3'b010, 4'b0000});

        for (int i = 0; i < 13; i++) do_access(vecs[i], $sformatf("v%0d", i));

        // Reset asserted while the bridge waits for read data.
        mem_addr = 30'd8; mem_wstrb = 4'h0; mem_valid = 1'b1; axi_arready = 1'b1;
        @(negedge clk);
        chk("midrst arvalid", axi_arvalid, 1'b1);
        @(negedge clk);
        axi_arready = 1'b0;
        chk("midrst rready", axi_rready, 1'b1);
        #2 reset = 1'b0;
        #1 chk("midrst async clear", {axi_arvalid, axi_rready, mem_ready}, 3'b000);
        @(negedge clk);
        mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        any_out = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            any_out |= mem_ready | axi_arvalid | axi_rready | axi_awvalid | axi_wvalid;
        end
        chk("midrst no completion", any_out, 1'b0);
        do_access(mk(0, 30'd8, 32'h0, 4'h0, 0, 0, 2'b00, 1, 32'h8888_0008, 0, 2), "post-reset read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
